// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 16 ticks per bit, 2-of-3 majority at ticks 7/8/9,
// 5-8 data bits, optional parity, 1 or 2 stop bits, first-word fall-through FIFO.
module uart_rx_ovs #(
  parameter int CLK_FREQ   = 20000000,
  parameter int BAUD_RATE  = 57600,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_pin,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [7:0]                    rx_data,
  output logic                          rx_err_frame,
  output logic                          rx_err_parity,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int DEF_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam logic [DIV_W-1:0] DEF_DIV = (DEF_RAW < 1) ? DIV_W'(1) : DIV_W'(DEF_RAW);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } entry_t;

  state_e           st_q;
  logic             s1_q, s2_q;
  logic [DIV_W-1:0] div_q, pre_q;
  logic [1:0]       bits_q, pmode_q;
  logic             stop2_q;
  logic [3:0]       idx_q;
  logic [2:0]       bit_cnt_q;
  logic             smp7_q, smp8_q;
  logic [7:0]       data_q;
  logic             par_q, perr_q, ferr_q, stop_n_q;

  logic rx_s, tick, dec, bit_end, maj, par_en, last_stop, push;
  logic [2:0] last_bit;
  entry_t push_e;

  assign rx_s      = s2_q;
  assign tick      = (pre_q == div_q - DIV_W'(1));
  assign dec       = tick && (idx_q == 4'd9);
  assign bit_end   = tick && (idx_q == 4'd15);
  assign maj       = (smp7_q & smp8_q) | (smp7_q & rx_s) | (smp8_q & rx_s);
  assign par_en    = (pmode_q == 2'd1) || (pmode_q == 2'd2);
  assign last_stop = !stop2_q || stop_n_q;
  assign last_bit  = {1'b0, bits_q} + 3'd4;
  assign push      = (st_q == STOP) && dec && last_stop;
  assign push_e    = '{ferr: ferr_q | ~maj, perr: perr_q, data: data_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      st_q      <= IDLE;
      div_q     <= DEF_DIV;
      bits_q    <= '0;
      pmode_q   <= '0;
      stop2_q   <= 1'b0;
      pre_q     <= '0;
      idx_q     <= '0;
      bit_cnt_q <= '0;
      smp7_q    <= 1'b1;
      smp8_q    <= 1'b1;
      data_q    <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      stop_n_q  <= 1'b0;
    end else begin
      s1_q <= rx_pin;
      s2_q <= s1_q;
      case (st_q)
        IDLE: begin
          pre_q <= '0;
          idx_q <= '0;
          if (!rx_s) begin
            div_q     <= (cfg_div == '0) ? DEF_DIV : cfg_div;
            bits_q    <= cfg_bits;
            pmode_q   <= cfg_parity;
            stop2_q   <= cfg_stop2;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop_n_q  <= 1'b0;
            st_q      <= START;
          end
        end
        WAIT_HIGH: if (rx_s) st_q <= IDLE;
        default: begin
          if (tick) begin
            pre_q <= '0;
            idx_q <= idx_q + 4'd1;
          end else begin
            pre_q <= pre_q + DIV_W'(1);
          end
          if (tick && idx_q == 4'd7) smp7_q <= rx_s;
          if (tick && idx_q == 4'd8) smp8_q <= rx_s;
          case (st_q)
            START: begin
              if (dec && maj)   st_q <= IDLE;
              else if (bit_end) st_q <= DATA;
            end
            DATA: begin
              if (dec) begin
                data_q[bit_cnt_q] <= maj;
                par_q             <= par_q ^ maj;
              end
              if (bit_end) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == last_bit) st_q <= par_en ? PARITY : STOP;
              end
            end
            PARITY: begin
              if (dec)     perr_q <= ((par_q ^ maj) != (pmode_q == 2'd2));
              if (bit_end) st_q   <= STOP;
            end
            STOP: begin
              // A low line after the last stop must not be read as a new start bit.
              if (dec) begin
                if (last_stop) begin
                  st_q <= rx_s ? IDLE : WAIT_HIGH;
                end else begin
                  ferr_q   <= ferr_q | ~maj;
                  stop_n_q <= 1'b1;
                end
              end
            end
            default: st_q <= IDLE;
          endcase
        end
      endcase
    end
  end

  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            ovr_q;
  logic            full, pop, wr_en;
  entry_t          head;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);
  assign head  = mem_q[rd_q];

  assign rx_valid      = (cnt_q != '0);
  assign rx_data       = rx_valid ? head.data : 8'h00;
  assign rx_err_frame  = rx_valid & head.ferr;
  assign rx_err_parity = rx_valid & head.perr;
  assign rx_overrun    = ovr_q;
  assign fifo_count    = cnt_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) ovr_q <= 1'b1;
      else if (clr_overrun)     ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: directed and random frames checked against a queue model
// that derives each entry from the transmitted bit sequence.
module tb_uart_rx_ovs;
  localparam int DEPTH   = 4;
  localparam int DEF_DIV = 20000000 / (57600 * 16);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_pin = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_err_frame, rx_err_parity, rx_valid, rx_overrun;
  logic        rx_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad = 0;
  logic [9:0] mq[$];
  logic m_ovr = 1'b0;

  uart_rx_ovs #(.CLK_FREQ(20000000), .BAUD_RATE(57600), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .cfg_div(cfg_div), .cfg_bits(cfg_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_data(rx_data),
    .rx_err_frame(rx_err_frame), .rx_err_parity(rx_err_parity), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mpush(input logic [9:0] e);
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(e);
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, "_ovr"}, 32'(rx_overrun), 32'(m_ovr));
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    e = mq.pop_front();
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(e[7:0]));
    chk({tag, "_perr"}, 32'(rx_err_parity), 32'(e[8]));
    chk({tag, "_ferr"}, 32'(rx_err_frame), 32'(e[9]));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_chk(tag);
    chk({tag, "_empty_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_empty_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_empty_cnt"}, 32'(fifo_count), 32'd0);
  endtask

  // Sends one character starting at a negedge. sbad: 1 corrupts the first stop bit,
  // 2 the second. pop_at/abort_at are clock offsets from the start-bit edge (-1 = never).
  task automatic send_frame(input logic [7:0] d, input int nb, input int pm, input bit s2,
                            input bit pflip, input int sbad, input int dv, input int pop_at,
                            input bit scr, input int abort_at);
    logic b[$];
    logic [7:0] dm;
    logic p, fe, pe;
    int bt, cyc;
    dm = d & 8'((1 << nb) - 1);
    cfg_div = 16'(dv); cfg_bits = 2'(nb - 5); cfg_parity = 2'(pm); cfg_stop2 = s2;
    bt = 16 * ((dv == 0) ? DEF_DIV : dv);
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) b.push_back(dm[i]);
    pe = 1'b0;
    if (pm == 1 || pm == 2) begin
      p = (^dm) ^ (pm == 2) ^ pflip;
      b.push_back(p);
      pe = (((^dm) ^ p) != (pm == 2));
    end
    b.push_back(sbad != 1);
    fe = (sbad == 1);
    if (s2) begin
      b.push_back(sbad != 2);
      fe = fe | (sbad == 2);
    end
    cyc = 0;
    foreach (b[i]) begin
      rx_pin = b[i];
      for (int k = 0; k < bt; k++) begin
        if (cyc == abort_at) begin
          rst = 1'b1; rx_pin = 1'b1; rx_ready = 1'b0;
          return;
        end
        if (scr && cyc == 2 * bt) begin
          cfg_div = 16'($urandom_range(4)); cfg_bits = 2'($urandom_range(3));
          cfg_parity = 2'($urandom_range(3)); cfg_stop2 = 1'($urandom_range(1));
        end
        rx_ready = (cyc == pop_at);
        @(negedge clk);
        cyc++;
      end
    end
    rx_pin = 1'b1;
    rx_ready = 1'b0;
    mpush({fe, pe, dm});
    repeat (2 * bt) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d);
    send_frame(d, 8, 0, 1'b0, 1'b0, 0, 4, -1, 1'b0, -1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovr", 32'(rx_overrun), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_errs", 32'({rx_err_frame, rx_err_parity}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 at div 4
    send8(8'hA5);
    chk_state("a5");
    pop_chk("a5");
    chk("a5_after_valid", 32'(rx_valid), 32'd0);
    chk("a5_after_data", 32'(rx_data), 32'd0);

    // 7E1 0x41 with correct then wrong parity bit
    send_frame(8'h41, 7, 1, 1'b0, 1'b0, 0, 4, -1, 1'b0, -1);
    send_frame(8'h41, 7, 1, 1'b0, 1'b1, 0, 4, -1, 1'b0, -1);
    chk_state("7e1");
    drain("7e1");

    // glitch shorter than half a bit
    rx_pin = 1'b0;
    repeat (20) @(negedge clk);
    rx_pin = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_count", 32'(fifo_count), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);

    // break: 12 bit times low, one framing-error entry, then a clean 0x3C
    cfg_div = 16'd4; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    rx_pin = 1'b0;
    repeat (12 * 64) @(negedge clk);
    mpush({1'b1, 1'b0, 8'h00});
    chk_state("break");
    repeat (256) @(negedge clk);
    chk_state("break_hold");
    rx_pin = 1'b1;
    repeat (64) @(negedge clk);
    send8(8'h3C);
    chk_state("break_after");
    drain("break");

    // overrun without pop, then clear
    for (int v = 1; v <= 5; v++) send8(8'(v));
    chk_state("ovr");
    chk("ovr_head", 32'(rx_data), 32'(mq[0][7:0]));
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    m_ovr = 1'b0;
    chk("ovr_clr", 32'(rx_overrun), 32'd0);
    drain("ovr");

    // full FIFO with a pop in the same cycle as the 5th push
    for (int v = 1; v <= 4; v++) send8(8'(v));
    void'(mq.pop_front());
    send_frame(8'h05, 8, 0, 1'b0, 1'b0, 0, 4, 618, 1'b0, -1);
    chk_state("ovr_pop");
    drain("ovr_pop");

    // default divisor
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 0, 0, -1, 1'b0, -1);
    chk_state("defdiv");
    drain("defdiv");

    // random frames, config scrambled mid-frame on some
    for (int it = 0; it < 14; it++) begin
      send_frame(8'($urandom), 5 + int'($urandom_range(3)), int'($urandom_range(3)),
                 1'($urandom_range(1)), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0) ? int'($urandom_range(1, 2)) : 0,
                 int'($urandom_range(1, 4)), -1, 1'($urandom_range(1)), -1);
      chk_state("rnd");
      if (mq.size() >= 3 || $urandom_range(1) == 1) drain("rnd");
    end
    drain("rnd_end");

    // reset in the middle of the data bits with an entry already queued
    send8(8'h11);
    send_frame(8'h55, 8, 0, 1'b0, 1'b0, 0, 4, -1, 1'b0, 4 * 64);
    #1;
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'd0);
    chk("mid_rst_ovr", 32'(rx_overrun), 32'd0);
    mq.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h96, 8, 2, 1'b1, 1'b0, 0, 4, -1, 1'b0, -1);
    chk_state("8o2");
    drain("8o2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
